am_insertion_module: RTL
========================

# am_insertion_module

Transmit-side alignment-marker inserter for one PCS lane of the 100GbE multi-lane distribution path. It sits after block distribution and scrambling, counts data blocks on its lane, and inserts one 66-bit alignment marker every N_BLOCKS data blocks. Each marker carries the lane-specific marker bytes and the BIP3/BIP7 parity of all bits since the previous marker, which the receive-side AM lock and BIP checker rely on. Upstream is stalled for one slot per marker through a ready/valid handshake.

## Interface
- LEN_CODED_BLOCK, 66: coded block width.
- N_ALIGNER, 20: number of PCS lanes.
- NB_LANE_ID, $clog2(N_ALIGNER): lane id width.
- N_BLOCKS, 16383: data blocks between markers (≥1); the period is N_BLOCKS+1 including the AM.
- NB_BIP, 8: BIP width.
- NB_COUNTER, $clog2(N_BLOCKS): block counter width.

- i_clock  in  1  sole clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  clock enable; low freezes all state.
- i_valid  in  1  i_data holds a block.
- i_data  in  LEN_CODED_BLOCK  block; [65:64] is the sync header, first transmitted bit is MSB.
- i_lane_id  in  NB_LANE_ID  selects marker bytes; sampled when an AM is emitted.
- o_ready  out  1  block accepted this cycle if i_valid; combinational.
- o_data  out  LEN_CODED_BLOCK  output block.
- o_valid  out  1  o_data valid.
- o_am_flag  out  1  o_data is an alignment marker.
- o_bip3  out  NB_BIP  BIP3 of the last emitted AM.

## Operation
- Transfer: i_enable && i_valid && o_ready.
- FSM states:
  - DATA: o_ready = i_enable. Each transfer increments the counter and XORs the block parity into bip_acc. A transfer with count == N_BLOCKS-1 clears the count and moves to INSERT.
  - INSERT: o_ready = 0. On the first cycle with i_enable, emit the AM, set bip_acc to the parity of that AM, and move to DATA. i_valid is ignored.
- AM layout: {2'b10, M0, M1, M2, BIP3, ~M0, ~M1, ~M2, ~BIP3}.
  - BIP3 = bip_acc.
  - M0..M2 come from the package table indexed by i_lane_id; i_lane_id ≥ N_ALIGNER uses lane 0.
- Block parity follows the 802.3 BIP mapping. With transmitted bit k = vector bit 65-k:
  - BIP bit i = XOR of transmitted bits 2+i+8m, m = 0..7.
  - Transmitted bit 0 also feeds BIP bit 3; transmitted bit 1 also feeds BIP bit 4.
  - Equivalently: bit-reverse of the XOR of the 8 payload bytes, ^08 if sync[65], ^10 if sync[64].
  - Every AM has parity 8'h08.
- i_lane_id changes take effect at the next AM only.
- Reset: state INSERT, count 0, bip_acc 0. The first output after reset is an AM with BIP3 = 00, BIP7 = FF.
- Reset mid-period discards the partial count and parity.

## Timing
- o_data, o_valid, o_am_flag and o_bip3 are registered; o_ready is combinational from state and i_enable.
- Reset values: o_data 0, o_valid 0, o_am_flag 0, o_bip3 0; o_ready 0.
- Latency: an accepted block appears on o_data the next cycle.
- An AM appears the cycle after the INSERT-state enabled cycle.
- o_valid = 1 exactly on cycles following a transfer or an AM emission, else 0.
- i_enable low: o_valid 0 next cycle, o_data holds, counter, bip_acc and state hold.
- Upstream holds i_data/i_valid while o_ready is 0; no block is dropped or duplicated.
- Steady state with continuous i_valid: exactly one o_ready-low cycle per N_BLOCKS+1 cycles.

## Structure
- Shared package:
  - lane marker table (20 × 24 bits: lane0 C16821, lane5 DD14C2, …, lane19 C0F0E5),
  - CTRL_SH 2'b10, LEN_AM 48,
  - FSM state encoding.
- Sub-module am_bip_parity: combinational 66→8 block parity, reused by the receive-side BIP checker.
- Top holds the FSM, counter, bip_acc and output register.

## Test plan
- Reset with lane_id 0, N_BLOCKS 4, i_enable 1 → first o_valid cycle: o_data = {10, C1 68 21 00 3E 97 DE FF}, o_am_flag 1, o_bip3 00.
- After that AM, send 4 blocks {01, 64'h0} → next AM BIP3 = 08, BIP7 = F7, with exactly 4 data outputs in between.
- Send {01, 64'h80000000_00000000} then 3 blocks {01, 64'h0} → next AM BIP3 = 09, BIP7 = F6.
- Continuous i_valid with blocks D1..D9, N_BLOCKS 4:
  - o_ready is low one cycle after each D4/D8 transfer;
  - output sequence is AM, D1..D4, AM, D5..D8, AM, D9, with no loss or duplication.
- In INSERT, drop i_enable for 3 cycles → o_valid 0 for those cycles; AM emitted on the first enabled cycle; counter unchanged.
- Reset after 2 data blocks with lane_id 5 → next output is {10, DD 14 C2 00 22 EB 3D FF}, count restarts from 0.

Source files
------------

// File: rtl/am_insertion_module_pkg.sv
// Shared constants, FSM encoding and per-lane alignment-marker table for the
// transmit AM inserter and the receive-side AM/BIP logic.
package am_insertion_module_pkg;

  localparam int LEN_BLOCK      = 66;
  localparam int BIP_WIDTH      = 8;
  localparam int N_LANES        = 20;
  localparam int LEN_AM         = 48;
  localparam int AM_MARKER_BITS = LEN_AM / 2;

  localparam logic [1:0] CTRL_SH = 2'b10;

  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_INSERT = 1'b1
  } am_state_e;

  // M0,M1,M2 per PCS lane; unknown lanes fall back to lane 0.
  function automatic logic [AM_MARKER_BITS-1:0] am_lane_marker(input logic [31:0] lane);
    logic [AM_MARKER_BITS-1:0] m;
    case (lane)
      32'd0:   m = 24'hC16821;
      32'd1:   m = 24'h9D718E;
      32'd2:   m = 24'h594BE8;
      32'd3:   m = 24'h4D957B;
      32'd4:   m = 24'hF50709;
      32'd5:   m = 24'hDD14C2;
      32'd6:   m = 24'h9A4A26;
      32'd7:   m = 24'h7B4566;
      32'd8:   m = 24'hA02476;
      32'd9:   m = 24'h68C9FB;
      32'd10:  m = 24'hFD6C99;
      32'd11:  m = 24'hB99155;
      32'd12:  m = 24'h5CB9B2;
      32'd13:  m = 24'h1AF8BD;
      32'd14:  m = 24'h83C7CA;
      32'd15:  m = 24'h3536CD;
      32'd16:  m = 24'hC4314C;
      32'd17:  m = 24'hADD6B7;
      32'd18:  m = 24'h5F662A;
      32'd19:  m = 24'hC0F0E5;
      default: m = 24'hC16821;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/am_bip_parity.sv
// Combinational BIP contribution of one 66-bit coded block; shared by the
// transmit inserter and the receive-side BIP checker.
module am_bip_parity
  import am_insertion_module_pkg::*;
(
  input  logic [LEN_BLOCK-1:0] i_block,
  output logic [BIP_WIDTH-1:0] o_bip
);

  logic [7:0] byte_xor;
  logic [7:0] byte_rev;

  always_comb begin
    byte_xor = '0;
    for (int j = 0; j < 8; j++) begin
      byte_xor = byte_xor ^ i_block[63-8*j -: 8];
    end
  end

  // Transmission order is MSB first, so BIP bit i lands on payload bit 7-i.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rev
    assign byte_rev[gi] = byte_xor[7-gi];
  end

  // The two sync-header bits fold into BIP bits 3 and 4.
  always_comb begin
    o_bip    = byte_rev;
    o_bip[3] = byte_rev[3] ^ i_block[65];
    o_bip[4] = byte_rev[4] ^ i_block[64];
  end

endmodule

// File: rtl/am_insertion_module.sv
// Per-lane alignment-marker inserter: passes scrambled blocks through and
// inserts one marker carrying BIP3/BIP7 every N_BLOCKS data blocks.
module am_insertion_module
  import am_insertion_module_pkg::*;
#(
  parameter int unsigned LEN_CODED_BLOCK = 66,
  parameter int unsigned N_ALIGNER       = 20,
  parameter int unsigned NB_LANE_ID      = $clog2(N_ALIGNER),
  parameter int unsigned N_BLOCKS        = 16383,
  parameter int unsigned NB_BIP          = 8,
  parameter int unsigned NB_COUNTER      = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic [LEN_CODED_BLOCK-1:0] i_data,
  input  logic [NB_LANE_ID-1:0]      i_lane_id,
  output logic                       o_ready,
  output logic [LEN_CODED_BLOCK-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_am_flag,
  output logic [NB_BIP-1:0]          o_bip3
);

  localparam logic [NB_COUNTER-1:0] LAST_COUNT = NB_COUNTER'(N_BLOCKS - 1);

  am_state_e                  state_q, state_d;
  logic [NB_COUNTER-1:0]      count_q, count_d;
  logic [NB_BIP-1:0]          bip_acc_q, bip_acc_d;
  logic [LEN_CODED_BLOCK-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       am_flag_q, am_flag_d;
  logic [NB_BIP-1:0]          bip3_q, bip3_d;

  logic [31:0]                lane_idx;
  logic [AM_MARKER_BITS-1:0]  marker;
  logic [LEN_CODED_BLOCK-1:0] am_block;
  logic [LEN_CODED_BLOCK-1:0] parity_in;
  logic [NB_BIP-1:0]          blk_parity;

  assign lane_idx = 32'(i_lane_id);
  assign marker   = (lane_idx < N_ALIGNER) ? am_lane_marker(lane_idx) : am_lane_marker(32'd0);
  assign am_block = {CTRL_SH, marker, bip_acc_q, ~marker, ~bip_acc_q};

  // One parity unit serves both paths: the incoming block in DATA, the
  // outgoing marker in INSERT (which seeds the next period's accumulator).
  assign parity_in = (state_q == ST_INSERT) ? am_block : i_data;

  am_bip_parity u_bip_parity (
    .i_block (parity_in),
    .o_bip   (blk_parity)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bip_acc_d = bip_acc_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    am_flag_d = am_flag_q;
    bip3_d    = bip3_q;
    o_ready   = 1'b0;

    case (state_q)
      ST_DATA: begin
        o_ready = i_enable;
        if (i_enable && i_valid) begin
          data_d    = i_data;
          valid_d   = 1'b1;
          am_flag_d = 1'b0;
          bip_acc_d = bip_acc_q ^ blk_parity;
          if (count_q == LAST_COUNT) begin
            count_d = '0;
            state_d = ST_INSERT;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_INSERT: begin
        if (i_enable) begin
          data_d    = am_block;
          valid_d   = 1'b1;
          am_flag_d = 1'b1;
          bip3_d    = bip_acc_q;
          bip_acc_d = blk_parity;
          state_d   = ST_DATA;
        end
      end
      default: state_d = ST_INSERT;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_INSERT;
      count_q   <= '0;
      bip_acc_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      am_flag_q <= 1'b0;
      bip3_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bip_acc_q <= bip_acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      am_flag_q <= am_flag_d;
      bip3_q    <= bip3_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_am_flag = am_flag_q;
  assign o_bip3    = bip3_q;

endmodule
